// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared register-file constants and the load-FIFO entry payload.
package reg_writeback_arbiter_pkg;

    localparam int unsigned RF_ADDR_W   = 5;
    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_NUM_REGS = 1 << RF_ADDR_W;

    localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 live;
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_arbiter_wb_fifo.sv
// Load-return FIFO with per-entry kill-by-destination and exposed entry vectors.
module reg_writeback_arbiter_wb_fifo
    import reg_writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  push,
    input  wb_entry_t                             push_entry,
    input  logic                                  pop,
    input  logic                                  kill_en,
    input  logic [RF_ADDR_W-1:0]                  kill_rd,
    output wb_entry_t                             head,
    output logic                                  full,
    output logic                                  empty,
    output logic [$clog2(DEPTH):0]                count,
    output logic [DEPTH-1:0]                      live_vec,
    output logic [DEPTH-1:0][RF_ADDR_W-1:0]       rd_vec
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              do_push;
    logic              do_pop;

    assign wr_idx  = wr_ptr[AW-1:0];
    assign rd_idx  = rd_ptr[AW-1:0];
    assign full    = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_idx];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Per-slot liveness restricted to occupied slots, plus destination of each slot.
    always_comb begin
        live_vec = '0;
        rd_vec   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            live_vec[i] = mem[i].live && (PW'(AW'(AW'(i) - rd_idx)) < count);
            rd_vec[i]   = mem[i].rd;
        end
    end

    // Storage and pointers; a same-cycle push overrides the kill on its own slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (kill_en) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (mem[i].rd == kill_rd) begin
                        mem[i].live <= 1'b0;
                    end
                end
            end
            if (do_push) begin
                mem[wr_idx] <= push_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Merges ALU and load writebacks onto the single register-file write port.
module reg_writeback_arbiter
    import reg_writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [ADDR_W-1:0]          ld_rd,
    input  logic [DATA_W-1:0]          ld_data,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic [RF_NUM_REGS-1:0]     busy_mask,
    output logic                       alu_stall,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       proto_err
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    wb_entry_t                        head;
    wb_entry_t                        push_entry;
    logic                             full;
    logic                             empty;
    logic                             push;
    logic                             pop;
    logic                             kill_en;
    logic [RF_ADDR_W-1:0]             alu_rd_rf;
    logic                             head_live;
    logic                             head_forced;
    logic                             alu_win;
    logic                             head_win;
    logic                             head_hit;
    logic [DEPTH-1:0]                 live_vec;
    logic [DEPTH-1:0][RF_ADDR_W-1:0]  rd_vec;
    logic [SW-1:0]                    starve_cnt;
    logic                             nxt_en;
    logic [ADDR_W-1:0]                nxt_addr;
    logic [DATA_W-1:0]                nxt_data;

    assign alu_rd_rf  = RF_ADDR_W'(alu_rd);
    assign push_entry = '{live: 1'b1, rd: RF_ADDR_W'(ld_rd), data: RF_DATA_W'(ld_data)};
    assign ld_ready   = !full;
    assign push       = ld_valid && !full && (RF_ADDR_W'(ld_rd) != REG_ZERO);
    assign alu_stall  = (starve_cnt >= SW'(STARVE_MAX));

    reg_writeback_arbiter_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (kill_en),
        .kill_rd    (alu_rd_rf),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (fifo_count),
        .live_vec   (live_vec),
        .rd_vec     (rd_vec)
    );

    // Arbitration: starved live head beats the ALU, else ALU, else head; killed heads are flushed.
    always_comb begin
        head_live   = !empty && head.live;
        head_forced = alu_stall && head_live;
        alu_win     = alu_valid && !head_forced;
        head_win    = head_forced || (!alu_valid && head_live);
        kill_en     = alu_win && (alu_rd_rf != REG_ZERO);
        head_hit    = kill_en && !empty && (head.rd == alu_rd_rf);
        pop         = !empty && (!head.live || head_win || head_hit);
        nxt_en      = 1'b0;
        nxt_addr    = ADDR_W'(head.rd);
        nxt_data    = DATA_W'(head.data);
        if (head_win) begin
            nxt_en = 1'b1;
        end else if (kill_en) begin
            nxt_en   = 1'b1;
            nxt_addr = alu_rd;
            nxt_data = alu_data;
        end
    end

    // Pending-write scoreboard over live entries.
    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_vec[i]) begin
                busy_mask[rd_vec[i]] = 1'b1;
            end
        end
    end

    // Write-port register; address and data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= nxt_en;
            if (nxt_en) begin
                wr_addr <= nxt_addr;
                wr_data <= nxt_data;
            end
        end
    end

    // Starvation counter and sticky dropped-ALU-write flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (empty || pop) begin
                starve_cnt <= '0;
            end else if (alu_win && head_live) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
            if (head_forced && alu_valid) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed self-checking bench for reg_writeback_arbiter.
module tb_reg_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] busy_mask;
    logic        alu_stall;
    logic [2:0]  fifo_count;
    logic        proto_err;

    int n_cmp = 0;
    int n_err = 0;

    reg_writeback_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy_mask  (busy_mask),
        .alu_stall  (alu_stall),
        .fifo_count (fifo_count),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %0h want 0", wr_en); end
        n_cmp++; if (wr_addr !== 5'd0) begin n_err++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
        n_cmp++; if (wr_data !== 32'd0) begin n_err++; $display("FAIL reset_wr_data: got %0h want 0", wr_data); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if (busy_mask !== 32'd0) begin n_err++; $display("FAIL reset_busy: got %0h want 0", busy_mask); end
        n_cmp++; if (alu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0h want 0", alu_stall); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_proto: got %0h want 0", proto_err); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_ld_ready: got %0h want 1", ld_ready); end
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234;
        tick();
        idle();
        n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd3, 32'h1234}) begin
            n_err++; $display("FAIL alu_write: got en=%0h a=%0d d=%0h want 1/3/1234", wr_en, wr_addr, wr_data); end
        tick();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL alu_idle_en: got %0h want 0", wr_en); end
        n_cmp++; if (wr_addr !== 5'd3) begin n_err++; $display("FAIL alu_hold_addr: got %0d want 3", wr_addr); end
    endtask

    task automatic test_load_only();
        ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hAA;
        tick();
        idle();
        n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL ld_count: got %0d want 1", fifo_count); end
        n_cmp++; if (busy_mask !== 32'h20) begin n_err++; $display("FAIL ld_busy: got %0h want 20", busy_mask); end
        tick();
        n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'hAA}) begin
            n_err++; $display("FAIL ld_write: got en=%0h a=%0d d=%0h want 1/5/aa", wr_en, wr_addr, wr_data); end
        n_cmp++; if (busy_mask !== 32'h0) begin n_err++; $display("FAIL ld_busy_clear: got %0h want 0", busy_mask); end
        tick();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL ld_idle_en: got %0h want 0", wr_en); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100 + 32'(k);
            ld_valid = 1'b1; ld_rd = 5'(8 + k); ld_data = 32'hB0 + 32'(k);
            tick();
        end
        n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL bp_count4: got %0d want 4", fifo_count); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL bp_ld_ready: got %0h want 0", ld_ready); end
        n_cmp++; if ({wr_addr, wr_data} !== {5'd1, 32'h103}) begin
            n_err++; $display("FAIL bp_alu_write: got a=%0d d=%0h want 1/103", wr_addr, wr_data); end
        alu_data = 32'h104; ld_rd = 5'd12; ld_data = 32'hBC;
        tick();
        idle();
        n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL bp_refused: got %0d want 4", fifo_count); end
        n_cmp++; if (busy_mask !== 32'h0F00) begin n_err++; $display("FAIL bp_busy: got %0h want f00", busy_mask); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'(8 + k), 32'hB0 + 32'(k)}) begin
                n_err++; $display("FAIL bp_drain%0d: got en=%0h a=%0d d=%0h want 1/%0d/%0h",
                                  k, wr_en, wr_addr, wr_data, 8 + k, 32'hB0 + 32'(k)); end
        end
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL bp_empty: got %0d want 0", fifo_count); end
        tick();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL bp_idle_en: got %0h want 0", wr_en); end
    endtask

    task automatic test_waw_kill();
        // Kill a non-head entry; it is flushed silently after the head drains.
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11; ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'h22;
        tick();
        alu_data = 32'h12; ld_rd = 5'd7; ld_data = 32'h77;
        tick();
        n_cmp++; if (busy_mask !== 32'h84) begin n_err++; $display("FAIL waw_busy2: got %0h want 84", busy_mask); end
        ld_valid = 1'b0; alu_rd = 5'd7; alu_data = 32'h55;
        tick();
        idle();
        n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd7, 32'h55}) begin
            n_err++; $display("FAIL waw_alu: got en=%0h a=%0d d=%0h want 1/7/55", wr_en, wr_addr, wr_data); end
        n_cmp++; if (busy_mask !== 32'h4) begin n_err++; $display("FAIL waw_busy_kill: got %0h want 4", busy_mask); end
        n_cmp++; if (fifo_count !== 3'd2) begin n_err++; $display("FAIL waw_count2: got %0d want 2", fifo_count); end
        tick();
        n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd2, 32'h22}) begin
            n_err++; $display("FAIL waw_head: got en=%0h a=%0d d=%0h want 1/2/22", wr_en, wr_addr, wr_data); end
        tick();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL waw_flush_en: got %0h want 0", wr_en); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL waw_flush_count: got %0d want 0", fifo_count); end
        // Kill the head itself in the ALU's cycle.
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        tick();
        idle(); alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h55;
        tick();
        idle();
        n_cmp++; if ({wr_en, wr_addr, wr_data, fifo_count, busy_mask} !== {1'b1, 5'd7, 32'h55, 3'd0, 32'h0}) begin
            n_err++; $display("FAIL waw_headkill: got en=%0h a=%0d d=%0h c=%0d b=%0h want 1/7/55/0/0",
                              wr_en, wr_addr, wr_data, fifo_count, busy_mask); end
        tick();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL waw_headkill_idle: got %0h want 0", wr_en); end
        // Same-cycle push is newer than the ALU write and survives.
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h66; ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h99;
        tick();
        idle();
        n_cmp++; if ({wr_addr, wr_data, busy_mask} !== {5'd7, 32'h66, 32'h80}) begin
            n_err++; $display("FAIL waw_newer_alu: got a=%0d d=%0h b=%0h want 7/66/80", wr_addr, wr_data, busy_mask); end
        tick();
        n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd7, 32'h99}) begin
            n_err++; $display("FAIL waw_newer_ld: got en=%0h a=%0d d=%0h want 1/7/99", wr_en, wr_addr, wr_data); end
        tick();
    endtask

    task automatic test_starvation();
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h600; ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h44;
        tick();
        ld_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            alu_data = 32'h600 + 32'(k);
            tick();
            if (k == 7) begin
                n_cmp++; if (alu_stall !== 1'b0) begin n_err++; $display("FAIL starve_k7: got %0h want 0", alu_stall); end
            end
            if (k == 8) begin
                n_cmp++; if (alu_stall !== 1'b1) begin n_err++; $display("FAIL starve_k8: got %0h want 1", alu_stall); end
                n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL starve_proto0: got %0h want 0", proto_err); end
            end
        end
        alu_data = 32'hDEAD;
        tick();
        n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd4, 32'h44}) begin
            n_err++; $display("FAIL starve_head: got en=%0h a=%0d d=%0h want 1/4/44", wr_en, wr_addr, wr_data); end
        n_cmp++; if ({proto_err, alu_stall, fifo_count} !== {1'b1, 1'b0, 3'd0}) begin
            n_err++; $display("FAIL starve_after: got p=%0h s=%0h c=%0d want 1/0/0", proto_err, alu_stall, fifo_count); end
        alu_data = 32'h777;
        tick();
        idle();
        n_cmp++; if ({wr_en, wr_addr, wr_data, proto_err} !== {1'b1, 5'd6, 32'h777, 1'b1}) begin
            n_err++; $display("FAIL starve_sticky: got en=%0h a=%0d d=%0h p=%0h want 1/6/777/1",
                              wr_en, wr_addr, wr_data, proto_err); end
        tick();
    endtask

    task automatic test_reg_zero();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF; ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hEE;
        tick();
        n_cmp++; if ({wr_en, fifo_count, busy_mask} !== {1'b0, 3'd0, 32'h0}) begin
            n_err++; $display("FAIL r0_first: got en=%0h c=%0d b=%0h want 0/0/0", wr_en, fifo_count, busy_mask); end
        tick();
        idle();
        n_cmp++; if ({wr_en, fifo_count} !== {1'b0, 3'd0}) begin
            n_err++; $display("FAIL r0_second: got en=%0h c=%0d want 0/0", wr_en, fifo_count); end
        tick();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL r0_after: got %0h want 0", wr_en); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
            ld_valid = 1'b1; ld_rd = 5'(9 + k); ld_data = 32'hC0 + 32'(k);
            tick();
        end
        n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL rst_pre_count: got %0d want 3", fifo_count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({wr_en, wr_addr, wr_data} !== {1'b0, 5'd0, 32'd0}) begin
            n_err++; $display("FAIL rst_async_wr: got en=%0h a=%0d d=%0h want 0/0/0", wr_en, wr_addr, wr_data); end
        n_cmp++; if ({fifo_count, busy_mask} !== {3'd0, 32'h0}) begin
            n_err++; $display("FAIL rst_async_fifo: got c=%0d b=%0h want 0/0", fifo_count, busy_mask); end
        n_cmp++; if ({proto_err, alu_stall, ld_ready} !== {1'b0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL rst_async_flags: got p=%0h s=%0h r=%0h want 0/0/1", proto_err, alu_stall, ld_ready); end
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++; if ({wr_en, fifo_count} !== {1'b0, 3'd0}) begin
            n_err++; $display("FAIL rst_no_partial: got en=%0h c=%0d want 0/0", wr_en, fifo_count); end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_load_only();
        test_back_to_back();
        test_waw_kill();
        test_starvation();
        test_reg_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
